// File: rtl/result_mem_arbiter.sv
// -----------------------------------------------------------------------------
// result_mem_arbiter
//   Shares one single-port result SRAM between an ALU write port and a readout
//   read port. Requests are sampled on each rising edge; a granted command is
//   driven to the SRAM (and the matching grant pulsed) for exactly one cycle.
//   Contested requests alternate round-robin. Read data comes back through a
//   short pipeline: SRAM data is captured one cycle after the command, then
//   presented on rd_data with a one-cycle rd_valid pulse the cycle after that.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   wr_req/wr_addr/wr_data      write request (held until wr_gnt)
//   wr_gnt                      one-cycle write grant pulse
//   rd_req/rd_addr              read request (held until rd_gnt)
//   rd_gnt                      one-cycle read grant pulse
//   rd_data/rd_valid            registered read result and its valid pulse
//   mem_cs_n/mem_web            SRAM chip select (active-low), write enable (0 = write)
//   mem_addr/mem_din/mem_dout   SRAM address, write data, read data
//   busy                        command or read return in flight
// -----------------------------------------------------------------------------
module result_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_cs_n,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  // Round-robin pointer: which requester wins the next contested cycle.
  typedef enum logic {
    PRI_WR = 1'b0,
    PRI_RD = 1'b1
  } pri_e;

  pri_e              pri_q, pri_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              cs_n_q, cs_n_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rd_s1_q, rd_s1_d;
  logic              rd_s2_q, rd_s2_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic wr_qual, rd_qual, grant_wr, grant_rd;

  // A requester whose grant is being pulsed right now is still holding its
  // request from before the grant, so it is not eligible at this edge.
  // rd_s1 marks the cycle in which mem_dout carries the read data; rd_s2 marks
  // the cycle in which that data sits in cap_q waiting to be presented.
  always_comb begin
    wr_qual  = wr_req & ~wr_gnt_q;
    rd_qual  = rd_req & ~rd_gnt_q;
    grant_wr = wr_qual & (~rd_qual | (pri_q == PRI_WR));
    grant_rd = rd_qual & ~grant_wr;

    wr_gnt_d = grant_wr;
    rd_gnt_d = grant_rd;
    cs_n_d   = ~(grant_wr | grant_rd);
    web_d    = ~grant_wr;
    addr_d   = addr_q;
    din_d    = din_q;
    pri_d    = pri_q;

    if (grant_wr) begin
      addr_d = wr_addr;
      din_d  = wr_data;
      pri_d  = PRI_RD;
    end else if (grant_rd) begin
      addr_d = rd_addr;
      pri_d  = PRI_WR;
    end

    rd_s1_d    = rd_gnt_q;
    rd_s2_d    = rd_s1_q;
    cap_d      = rd_s1_q ? mem_dout : cap_q;
    rd_valid_d = rd_s2_q;
    rd_data_d  = rd_s2_q ? cap_q : rd_data_q;
  end

  // Reset drops any in-flight read stages so no stale rd_valid can follow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_q      <= PRI_WR;
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      web_q      <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      rd_s1_q    <= 1'b0;
      rd_s2_q    <= 1'b0;
      cap_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      pri_q      <= pri_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_gnt_q   <= rd_gnt_d;
      cs_n_q     <= cs_n_d;
      web_q      <= web_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rd_s1_q    <= rd_s1_d;
      rd_s2_q    <= rd_s2_d;
      cap_q      <= cap_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign wr_gnt   = wr_gnt_q;
  assign rd_gnt   = rd_gnt_q;
  assign mem_cs_n = cs_n_q;
  assign mem_web  = web_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = ~cs_n_q | rd_s1_q | rd_s2_q | rd_valid_q;

endmodule

// File: tb/tb_result_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_result_mem_arbiter
//   Directed, table-driven bench for result_mem_arbiter with a behavioural
//   synchronous SRAM attached to the memory port, plus hand-written sequences
//   for reset behaviour and arbitration restart after reset.
// -----------------------------------------------------------------------------
module tb_result_mem_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int NVEC   = 23;

  logic              clk;
  logic              rst;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              mem_cs_n;
  logic              mem_web;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              busy;

  int pass_count;
  int check_count;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              rd;
    logic [ADDR_W-1:0] ra;
    logic              gw;
    logic              gr;
    logic              csn;
    logic              web;
    logic [ADDR_W-1:0] ma;
    logic [DATA_W-1:0] md;
    logic              rv;
    logic [DATA_W-1:0] rdat;
    logic              bsy;
  } vec_t;

  vec_t vecs [NVEC];

  result_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_gnt   (wr_gnt),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .mem_cs_n (mem_cs_n),
    .mem_web  (mem_web),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous SRAM: read data appears the cycle after the command.
  logic [DATA_W-1:0] sram [1<<ADDR_W];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = '0;
    mem_dout = '0;
  end
  always @(posedge clk) begin
    if (!mem_cs_n) begin
      if (!mem_web) sram[mem_addr] <= mem_din;
      else          mem_dout       <= sram[mem_addr];
    end
  end

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_req  = v.wr;
    wr_addr = v.wa;
    wr_data = v.wd;
    rd_req  = v.rd;
    rd_addr = v.ra;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput("wr_gnt",   idx, 32'(wr_gnt),   32'(v.gw));
    checkOutput("rd_gnt",   idx, 32'(rd_gnt),   32'(v.gr));
    checkOutput("mem_cs_n", idx, 32'(mem_cs_n), 32'(v.csn));
    checkOutput("mem_web",  idx, 32'(mem_web),  32'(v.web));
    checkOutput("mem_addr", idx, 32'(mem_addr), 32'(v.ma));
    checkOutput("mem_din",  idx, 32'(mem_din),  32'(v.md));
    checkOutput("rd_valid", idx, 32'(rd_valid), 32'(v.rv));
    checkOutput("rd_data",  idx, 32'(rd_data),  32'(v.rdat));
    checkOutput("busy",     idx, 32'(busy),     32'(v.bsy));
  endtask

  task automatic checkReset(input int idx);
    checkOutput("rst_wr_gnt",   idx, 32'(wr_gnt),   32'd0);
    checkOutput("rst_rd_gnt",   idx, 32'(rd_gnt),   32'd0);
    checkOutput("rst_rd_valid", idx, 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data",  idx, 32'(rd_data),  32'd0);
    checkOutput("rst_mem_cs_n", idx, 32'(mem_cs_n), 32'd1);
    checkOutput("rst_mem_web",  idx, 32'(mem_web),  32'd1);
    checkOutput("rst_mem_addr", idx, 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_din",  idx, 32'(mem_din),  32'd0);
    checkOutput("rst_busy",     idx, 32'(busy),     32'd0);
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;

    //          wr  wa     wd          rd  ra     gw  gr  csn web ma     md          rv  rdat        bsy
    vecs[0]  = '{1, 6'd5, 16'h1234, 0, 6'd0, 1, 0, 0, 0, 6'd5, 16'h1234, 0, 16'h0000, 1};
    vecs[1]  = '{0, 6'd0, 16'h0000, 1, 6'd5, 0, 1, 0, 1, 6'd5, 16'h1234, 0, 16'h0000, 1};
    vecs[2]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd5, 16'h1234, 0, 16'h0000, 1};
    vecs[3]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd5, 16'h1234, 0, 16'h0000, 1};
    vecs[4]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd5, 16'h1234, 1, 16'h1234, 1};
    vecs[5]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd5, 16'h1234, 0, 16'h1234, 0};
    vecs[6]  = '{1, 6'd9, 16'hBEEF, 1, 6'd9, 1, 0, 0, 0, 6'd9, 16'hBEEF, 0, 16'h1234, 1};
    vecs[7]  = '{1, 6'd9, 16'hBEEF, 1, 6'd9, 0, 1, 0, 1, 6'd9, 16'hBEEF, 0, 16'h1234, 1};
    vecs[8]  = '{1, 6'd9, 16'hBEEF, 0, 6'd0, 1, 0, 0, 0, 6'd9, 16'hBEEF, 0, 16'h1234, 1};
    vecs[9]  = '{1, 6'd9, 16'hBEEF, 0, 6'd0, 0, 0, 1, 1, 6'd9, 16'hBEEF, 0, 16'h1234, 1};
    vecs[10] = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd9, 16'hBEEF, 1, 16'hBEEF, 1};
    vecs[11] = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd9, 16'hBEEF, 0, 16'hBEEF, 0};
    vecs[12] = '{1, 6'd3, 16'h00AA, 0, 6'd0, 1, 0, 0, 0, 6'd3, 16'h00AA, 0, 16'hBEEF, 1};
    vecs[13] = '{1, 6'd3, 16'h00AA, 0, 6'd0, 0, 0, 1, 1, 6'd3, 16'h00AA, 0, 16'hBEEF, 0};
    vecs[14] = '{1, 6'd3, 16'h00AA, 0, 6'd0, 1, 0, 0, 0, 6'd3, 16'h00AA, 0, 16'hBEEF, 1};
    vecs[15] = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd3, 16'h00AA, 0, 16'hBEEF, 0};
    vecs[16] = '{1, 6'd4, 16'h5555, 1, 6'd3, 0, 1, 0, 1, 6'd3, 16'h00AA, 0, 16'hBEEF, 1};
    vecs[17] = '{1, 6'd4, 16'h5555, 1, 6'd3, 1, 0, 0, 0, 6'd4, 16'h5555, 0, 16'hBEEF, 1};
    vecs[18] = '{1, 6'd4, 16'h5555, 1, 6'd3, 0, 1, 0, 1, 6'd3, 16'h5555, 0, 16'hBEEF, 1};
    vecs[19] = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd3, 16'h5555, 1, 16'h00AA, 1};
    vecs[20] = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd3, 16'h5555, 0, 16'h00AA, 1};
    vecs[21] = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd3, 16'h5555, 1, 16'h00AA, 1};
    vecs[22] = '{0, 6'd0, 16'h0000, 0, 6'd0, 0, 0, 1, 1, 6'd3, 16'h5555, 0, 16'h00AA, 0};

    // Reset and idle inputs.
    rst     = 1'b1;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_req  = 1'b0;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkReset(-1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven main sequence: inputs before an edge, outputs checked after it.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkVector(i, vecs[i]);
    end

    // Reset in the middle of a read: no rd_valid may ever emerge.
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 6'd5;
    @(posedge clk);
    #1;
    checkOutput("mr_rd_gnt", 100, 32'(rd_gnt), 32'd1);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkReset(101);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("mr_rd_valid", 102 + i, 32'(rd_valid), 32'd0);
      checkOutput("mr_busy",     102 + i, 32'(busy),     32'd0);
    end

    // Arbitration restarts with the pointer favouring writes.
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = 6'd7;
    wr_data = 16'h7777;
    rd_req  = 1'b1;
    rd_addr = 6'd9;
    @(posedge clk);
    #1;
    checkOutput("rs_wr_gnt",   110, 32'(wr_gnt),   32'd1);
    checkOutput("rs_rd_gnt",   110, 32'(rd_gnt),   32'd0);
    checkOutput("rs_mem_addr", 110, 32'(mem_addr), 32'd7);
    checkOutput("rs_mem_din",  110, 32'(mem_din),  32'h7777);
    checkOutput("rs_mem_web",  110, 32'(mem_web),  32'd0);
    @(negedge clk);
    wr_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rs2_rd_gnt",   111, 32'(rd_gnt),   32'd1);
    checkOutput("rs2_wr_gnt",   111, 32'(wr_gnt),   32'd0);
    checkOutput("rs2_mem_addr", 111, 32'(mem_addr), 32'd9);
    checkOutput("rs2_mem_web",  111, 32'(mem_web),  32'd1);
    @(negedge clk);
    rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rs2_rd_valid", 112, 32'(rd_valid), 32'd1);
    checkOutput("rs2_rd_data",  112, 32'(rd_data),  32'hBEEF);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/result_mem_arbiter.md
RESULT_MEM_ARBITER -- requirements
Module: result_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, result-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, result word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_req  input  1  ALU-side write request, held until wr_gnt.
REQ-006 SHALL have port wr_addr  input  ADDR_W  write address, stable while wr_req high.
REQ-007 SHALL have port wr_data  input  DATA_W  write data, stable while wr_req high.
REQ-008 SHALL have port wr_gnt  output  1  one-cycle write-grant pulse.
REQ-009 SHALL have port rd_req  input  1  readout-side read request, held until rd_gnt.
REQ-010 SHALL have port rd_addr  input  ADDR_W  read address, stable while rd_req high.
REQ-011 SHALL have port rd_gnt  output  1  one-cycle read-grant pulse.
REQ-012 SHALL have port rd_data  output  DATA_W  registered read result.
REQ-013 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-014 SHALL have port mem_cs_n  output  1  SRAM chip select, active-low.
REQ-015 SHALL have port mem_web  output  1  SRAM write enable, 0 = write, 1 = read.
REQ-016 SHALL have port mem_addr  output  ADDR_W  SRAM address.
REQ-017 SHALL have port mem_din  output  DATA_W  SRAM write data.
REQ-018 SHALL have port mem_dout  input  DATA_W  SRAM read data, valid the cycle after a read command.
REQ-019 SHALL have port busy  output  1  high while any command or read return is in flight.

Function
REQ-020 SHALL sample requests at each rising edge; a requester whose grant is high in the current cycle SHALL be ignored at that edge (minimum 2 cycles between grants to the same requester).
REQ-021 SHALL, for a qualified request at edge E, drive the SRAM command and the matching grant pulse in the cycle after E; command lasts exactly one cycle (mem_cs_n=0).
REQ-022 SHALL, when no qualified request, drive mem_cs_n=1, mem_web=1; mem_addr/mem_din hold last value.
REQ-023 SHALL, write command: mem_web=0, mem_addr=wr_addr, mem_din=wr_data as sampled at E.
REQ-024 SHALL, read command: mem_web=1, mem_addr=rd_addr as sampled at E.
REQ-025 SHALL capture mem_dout at the end of the cycle after the read command and pulse rd_valid the following cycle: rd_req sampled at E -> rd_valid 3 cycles after E.
REQ-026 SHALL hold rd_data between rd_valid pulses.
REQ-027 SHALL arbitrate round-robin when both qualified: grant the requester not granted most recently; priority pointer updates only on a contested or uncontested grant.
REQ-028 SHALL grant a single qualified requester immediately regardless of pointer.
REQ-029 SHALL allow a command every cycle (alternating requesters); read return pipeline SHALL not stall writes.
REQ-030 SHALL preserve issue order: write then read to same address returns the new data.
REQ-031 SHALL assert busy when a command is being driven or a read return (capture or rd_valid stage) is pending.

Reset
REQ-032 SHALL on rst: wr_gnt=0, rd_gnt=0, rd_valid=0, rd_data=0, mem_cs_n=1, mem_web=1, mem_addr=0, mem_din=0, busy=0, pointer favours write.
REQ-033 SHALL on rst mid-operation discard any in-flight read; no rd_valid after reset release for pre-reset requests.
REQ-034 SHALL resume arbitration at the first rising edge after rst deasserts.

Verification
REQ-035 Write only: wr_req, wr_addr=5, wr_data=0x1234 at edge E -> next cycle mem_cs_n=0, mem_web=0, mem_addr=5, mem_din=0x1234, wr_gnt=1.
REQ-036 Read back: after REQ-035, rd_req rd_addr=5 at edge E -> rd_gnt at E+1, rd_valid=1 with rd_data=0x1234 in cycle after E+3 edge sequence (3 cycles after E).
REQ-037 Contention from reset: wr_req and rd_req both high, held -> grants W, R, W, R on consecutive command cycles.
REQ-038 Held request: wr_req kept high through wr_gnt with no rd_req -> wr_gnt every other cycle, never two consecutive.
REQ-039 Reset mid-read: rd_req granted, rst pulsed next cycle -> rd_valid never asserts, all outputs at reset values.
REQ-040 Same-address ordering: write addr 9 data 0xBEEF granted before read addr 9 -> rd_data=0xBEEF.
